load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the core's memory pipeline stage and the OBI controller's transaction request/response interface. It converts a typed access (byte/half/word, signed/unsigned) into a word-aligned request with byte enables and lane-replicated write data. It then waits for the response and returns the extracted, extended load data to the pipeline. It holds the pipeline stalled while a transaction is in flight and allows one outstanding access.

## Interface
Parameters:
- WIDTH, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- lsu_req_i  in  1  pipeline presents a memory access.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_type_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- lsu_sign_ext_i  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- lsu_addr_i  in  WIDTH  byte address.
- lsu_wdata_i  in  WIDTH  store data, right-aligned.
- lsu_stall_o  out  1  pipeline must hold its inputs.
- lsu_rvalid_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  WIDTH  extended load data; 0 for stores and errors.
- lsu_err_o  out  1  bus error, valid with lsu_rvalid_o.
- lsu_misaligned_o  out  1  one-cycle pulse on rejected access.
- core_valid_o  out  1  request valid to OBI controller.
- core_ready_i  in  1  controller accepts request.
- core_addr_o  out  WIDTH  word-aligned address, bits [1:0] = 00.
- core_we_o  out  1  write enable.
- core_be_o  out  4  byte enables.
- core_wdata_o  out  WIDTH  lane-replicated store data.
- resp_valid_i  in  1  response valid; consumer always ready.
- resp_rdata_i  in  WIDTH  response data word.
- resp_err_i  in  1  response error.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - On lsu_req_i with an aligned, legal access, latch we, type, sign, offset = addr[1:0], aligned address, be, and wdata, then go to REQ.
  - On lsu_req_i with a misaligned or illegal access, pulse lsu_misaligned_o the next cycle, stay in IDLE, and issue no request.
- **REQ**
  - core_valid_o = 1, with all core_* outputs driven from registers and stable.
  - core_valid_o & core_ready_i moves to RESP.
- **RESP**
  - On resp_valid_i, register the extracted data and resp_err_i, then go to DONE.
- **DONE**
  - lsu_rvalid_o = 1 for one cycle, then go to IDLE.
- resp_valid_i outside RESP is ignored.
- Stores also wait for their response; completion follows the same path with lsu_rdata_o = 0.
- lsu_stall_o is combinational:
  - In IDLE: 1 when lsu_req_i is high and the access is aligned and legal.
  - In REQ and RESP: 1.
  - In DONE: 0, so the pipeline advances on the completion cycle.
- Byte enables:
  - byte: 4'b0001 << offset
  - half: offset 0 gives 0011; offset 2 gives 1100
  - word: 1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data:
  - Shift resp_rdata_i right by 8*offset.
  - byte: extend from bit 7; half: extend from bit 15; sign- or zero-extend per latched sign.
  - resp_err_i = 1 gives lsu_rdata_o = 0 and lsu_err_o = 1.
- Alignment rules:
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - type 11 is always rejected.
- Reset values:
  - All outputs are 0, including core_addr_o, core_be_o, core_wdata_o, and lsu_rdata_o.
  - The state returns to IDLE.
- Reset in any state aborts the access. A late resp_valid_i arriving in IDLE is ignored.

## Timing
- Zero-wait path:
  - cycle 0: IDLE, accept.
  - cycle 1: REQ, ready = 1.
  - cycle 2: RESP, resp_valid_i.
  - cycle 3: DONE, lsu_rvalid_o.
  - Minimum accept-to-completion is 3 cycles.
- Each cycle with core_ready_i = 0 adds one REQ cycle. Each cycle without resp_valid_i adds one RESP cycle.
- Back-to-back accesses: the next access can be accepted in the cycle after DONE, giving a 4-cycle minimum issue interval.
- lsu_misaligned_o is registered and asserts the cycle after the offending request. lsu_stall_o stays 0 for that access.

## Configuration
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: misaligned and illegal detection is active as described in Operation.
- Undefined:
  - No access is rejected and lsu_misaligned_o is tied to 0.
  - Half accesses use offset {addr[1],0}; word accesses use offset 0.
  - Type 11 is treated as word.
  - The access is issued with the forced offset.

## Test plan
- Word store at 0x100, data 0xDEADBEEF, ready/rvalid zero-wait -> core_addr_o 0x100, be 1111, wdata 0xDEADBEEF; lsu_rvalid_o in cycle 3 with lsu_rdata_o 0.
- Signed byte load at 0x203, resp_rdata_i 0x80FF_0000 -> be 1000; lsu_rdata_o 0xFFFFFF80. Unsigned repeat -> 0x00000080.
- Half store at 0x302, data 0x0000ABCD, core_ready_i low for 3 cycles -> core_* outputs stable for 4 REQ cycles; be 1100; wdata 0xABCDABCD; lsu_stall_o high throughout.
- Word load at 0x401 with macro defined -> lsu_misaligned_o pulses once, core_valid_o never asserts. Without the macro -> core_addr_o 0x400 with be 1111.
- Load with resp_err_i = 1 -> lsu_err_o = 1 and lsu_rdata_o = 0 on the completion pulse.
- rst asserted in RESP, then resp_valid_i arrives after reset -> all outputs 0, state IDLE, no lsu_rvalid_o.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns typed pipeline accesses into word-aligned OBI requests and returns extended load data.
// Optional macro LSU_MISALIGN_CHECK_EN enables rejection of misaligned/illegal accesses.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_req_i,
  input  logic             lsu_we_i,
  input  logic [1:0]       lsu_type_i,
  input  logic             lsu_sign_ext_i,
  input  logic [WIDTH-1:0] lsu_addr_i,
  input  logic [WIDTH-1:0] lsu_wdata_i,
  output logic             lsu_stall_o,
  output logic             lsu_rvalid_o,
  output logic [WIDTH-1:0] lsu_rdata_o,
  output logic             lsu_err_o,
  output logic             lsu_misaligned_o,
  output logic             core_valid_o,
  input  logic             core_ready_i,
  output logic [WIDTH-1:0] core_addr_o,
  output logic             core_we_o,
  output logic [3:0]       core_be_o,
  output logic [WIDTH-1:0] core_wdata_o,
  input  logic             resp_valid_i,
  input  logic [WIDTH-1:0] resp_rdata_i,
  input  logic             resp_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       w_type_eff;
  logic [1:0]       w_off;
  logic             w_reject;
  logic             w_accept;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;

  logic             r_we;
  logic [1:0]       r_type;
  logic             r_sign;
  logic [1:0]       r_off;
  logic [WIDTH-1:0] r_addr;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic             r_misaligned;

  function automatic logic [WIDTH-1:0] extract_load(input logic [WIDTH-1:0] word,
                                                    input logic [1:0]       typ,
                                                    input logic             sgn,
                                                    input logic [1:0]       off);
    logic [WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (typ)
      2'b00:   extract_load = {{(WIDTH-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   extract_load = {{(WIDTH-16){sgn & sh[15]}}, sh[15:0]};
      default: extract_load = sh;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    w_type_eff = lsu_type_i;
    w_off      = lsu_addr_i[1:0];
    case (lsu_type_i)
      2'b01:   w_reject = lsu_addr_i[0];
      2'b10:   w_reject = |lsu_addr_i[1:0];
      2'b11:   w_reject = 1'b1;
      default: w_reject = 1'b0;
    endcase
  end
`else
  // Without checking, the offset is forced to the natural alignment of the size.
  always_comb begin
    w_reject   = 1'b0;
    w_type_eff = (lsu_type_i == 2'b11) ? 2'b10 : lsu_type_i;
    case (w_type_eff)
      2'b00:   w_off = lsu_addr_i[1:0];
      2'b01:   w_off = {lsu_addr_i[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end
`endif

  always_comb begin
    case (w_type_eff)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && lsu_req_i && !w_reject;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = REQ;
      REQ:     if (core_ready_i) w_state_nxt = RESP;
      RESP:    if (resp_valid_i) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      IDLE:    lsu_stall_o = w_accept;
      REQ:     lsu_stall_o = 1'b1;
      RESP:    lsu_stall_o = 1'b1;
      default: lsu_stall_o = 1'b0;
    endcase
  end

  // p0: request capture, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_type       <= 2'b00;
      r_sign       <= 1'b0;
      r_off        <= 2'b00;
      r_addr       <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_misaligned <= (r_state == IDLE) && lsu_req_i && w_reject;
      if (w_accept) begin
        r_we    <= lsu_we_i;
        r_type  <= w_type_eff;
        r_sign  <= lsu_sign_ext_i;
        r_off   <= w_off;
        r_addr  <= {lsu_addr_i[WIDTH-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if ((r_state == RESP) && resp_valid_i) begin
        r_err   <= resp_err_i;
        r_rdata <= (resp_err_i || r_we) ? '0 : extract_load(resp_rdata_i, r_type, r_sign, r_off);
      end
    end
  end

  assign core_valid_o     = (r_state == REQ);
  assign core_addr_o      = r_addr;
  assign core_we_o        = r_we;
  assign core_be_o        = r_be;
  assign core_wdata_o     = r_wdata;
  assign lsu_rvalid_o     = (r_state == DONE);
  assign lsu_rdata_o      = r_rdata;
  assign lsu_err_o        = r_err;
  assign lsu_misaligned_o = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: literal expectations per vector plus an arithmetic scoreboard model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_stall_o, lsu_rvalid_o, lsu_err_o, lsu_misaligned_o;
  logic [31:0] lsu_rdata_o;
  logic        core_valid_o, core_ready_i, core_we_o;
  logic [31:0] core_addr_o, core_wdata_o;
  logic [3:0]  core_be_o;
  logic        resp_valid_i, resp_err_i;
  logic [31:0] resp_rdata_i;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_stall_o(lsu_stall_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .lsu_misaligned_o(lsu_misaligned_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .core_addr_o(core_addr_o),
    .core_we_o(core_we_o), .core_be_o(core_be_o), .core_wdata_o(core_wdata_o),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } comp_t;

  typedef struct {
    logic        we;
    logic [1:0]  t;
    logic        s;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          rsp;
    logic [31:0] rword;
    logic        err;
    logic        rej;
    logic [31:0] l_addr;
    logic [3:0]  l_be;
    logic [31:0] l_wd;
    logic [31:0] l_rd;
  } vec_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    mis_pending = 0;
  bit    mon_en = 0;
  req_t  rq[$];
  comp_t cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input int t);
    return (t == 0) ? 1 : (t == 1) ? 2 : 4;
  endfunction

  function automatic int m_off(input int t, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return int'(a % 4);
`else
    if (t == 0) return int'(a % 4);
    if (t == 1) return int'(a % 4) & 2;
    return 0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input int t, input logic [31:0] a);
    int m;
    m = ((1 << m_size(t)) - 1) << m_off(t, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int t, input logic [31:0] d);
    longint v;
    if (t == 0)      v = longint'(d % 256) * 64'h0101_0101;
    else if (t == 1) v = longint'(d % 65536) * 64'h0001_0001;
    else             v = longint'(d);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int t, input bit s, input int off);
    longint v, span;
    span = longint'(1) << (8 * m_size(t));
    v = (longint'(w) >> (8 * off)) % span;
    if (s && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (core_valid_o) begin
        chk("req_outstanding", 32'(rq.size()), 32'd1);
        if (rq.size() > 0) begin
          chk("mdl_core_addr", core_addr_o, rq[0].addr);
          chk("mdl_core_be", {28'd0, core_be_o}, {28'd0, rq[0].be});
          chk("mdl_core_wdata", core_wdata_o, rq[0].wdata);
          chk("mdl_core_we", {31'd0, core_we_o}, {31'd0, rq[0].we});
          if (core_ready_i) void'(rq.pop_front());
        end
      end
      if (lsu_rvalid_o) begin
        chk("cmp_outstanding", 32'(cq.size()), 32'd1);
        if (cq.size() > 0) begin
          chk("mdl_rdata", lsu_rdata_o, cq[0].rdata);
          chk("mdl_err", {31'd0, lsu_err_o}, {31'd0, cq[0].err});
          void'(cq.pop_front());
        end
      end
      if (lsu_misaligned_o) begin
        chk("mis_expected", 32'(mis_pending), 32'd1);
        if (mis_pending > 0) mis_pending--;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, lsu_stall_o}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, lsu_rvalid_o}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata_o, 32'd0);
    chk({tag, "_err"}, {31'd0, lsu_err_o}, 32'd0);
    chk({tag, "_mis"}, {31'd0, lsu_misaligned_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, core_valid_o}, 32'd0);
    chk({tag, "_addr"}, core_addr_o, 32'd0);
    chk({tag, "_we"}, {31'd0, core_we_o}, 32'd0);
    chk({tag, "_be"}, {28'd0, core_be_o}, 32'd0);
    chk({tag, "_wdata"}, core_wdata_o, 32'd0);
  endtask

  task automatic drive_req(input vec_t v);
    lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_type_i = v.t; lsu_sign_ext_i = v.s;
    lsu_addr_i = v.addr; lsu_wdata_i = v.wdata; core_ready_i = 1'b0;
  endtask

  task automatic push_model(input vec_t v, input bit with_cmp);
    req_t  r;
    comp_t c;
    r.addr  = (v.addr / 4) * 4;
    r.be    = m_be(int'(v.t), v.addr);
    r.wdata = m_wdata(int'(v.t), v.wdata);
    r.we    = v.we;
    rq.push_back(r);
    if (with_cmp) begin
      c.err   = v.err;
      c.rdata = (v.we || v.err) ? 32'd0 : m_load(v.rword, int'(v.t), v.s, m_off(int'(v.t), v.addr));
      cq.push_back(c);
    end
  endtask

  task automatic chk_req_lit(input vec_t v, input string tag);
    chk({tag, "_valid"}, {31'd0, core_valid_o}, 32'd1);
    chk({tag, "_stall"}, {31'd0, lsu_stall_o}, 32'd1);
    chk({tag, "_addr"}, core_addr_o, v.l_addr);
    chk({tag, "_be"}, {28'd0, core_be_o}, {28'd0, v.l_be});
    chk({tag, "_wdata"}, core_wdata_o, v.l_wd);
  endtask

  task automatic run_vec(input vec_t v);
    drive_req(v);
    if (v.rej) begin
      mis_pending++;
      @(negedge clk);
      chk("rej_stall", {31'd0, lsu_stall_o}, 32'd0);
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      @(negedge clk);
      chk("rej_mis_pulse", {31'd0, lsu_misaligned_o}, 32'd1);
      chk("rej_no_valid", {31'd0, core_valid_o}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rej_mis_clear", {31'd0, lsu_misaligned_o}, 32'd0);
      chk("rej_no_valid2", {31'd0, core_valid_o}, 32'd0);
      @(posedge clk); #1;
    end else begin
      push_model(v, 1'b1);
      @(negedge clk);
      chk("acc_stall", {31'd0, lsu_stall_o}, 32'd1);
      chk("acc_no_valid", {31'd0, core_valid_o}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < v.rdy; i++) begin
        @(negedge clk);
        chk_req_lit(v, "req_wait");
        @(posedge clk); #1;
      end
      core_ready_i = 1'b1;
      @(negedge clk);
      chk_req_lit(v, "req_hs");
      @(posedge clk); #1;
      core_ready_i = 1'b0;
      for (int i = 0; i < v.rsp; i++) begin
        @(negedge clk);
        chk("resp_wait_stall", {31'd0, lsu_stall_o}, 32'd1);
        chk("resp_wait_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        chk("resp_wait_valid", {31'd0, core_valid_o}, 32'd0);
        @(posedge clk); #1;
      end
      resp_valid_i = 1'b1; resp_rdata_i = v.rword; resp_err_i = v.err;
      @(negedge clk);
      chk("resp_stall", {31'd0, lsu_stall_o}, 32'd1);
      chk("resp_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
      @(posedge clk); #1;
      resp_valid_i = 1'b0; resp_err_i = 1'b0;
      @(negedge clk);
      chk("done_rvalid", {31'd0, lsu_rvalid_o}, 32'd1);
      chk("done_stall", {31'd0, lsu_stall_o}, 32'd0);
      chk("done_rdata", lsu_rdata_o, v.l_rd);
      chk("done_err", {31'd0, lsu_err_o}, {31'd0, v.err});
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] t, input logic s,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdy, input int rsp, input logic [31:0] rword,
                              input logic err, input logic rej, input logic [31:0] l_addr,
                              input logic [3:0] l_be, input logic [31:0] l_wd,
                              input logic [31:0] l_rd);
    vec_t v;
    v.we = we; v.t = t; v.s = s; v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.rsp = rsp;
    v.rword = rword; v.err = err; v.rej = rej; v.l_addr = l_addr; v.l_be = l_be;
    v.l_wd = l_wd; v.l_rd = l_rd;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t vr;

    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h12345678, 0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h203, 32'h0, 0, 0, 32'h80FF0000, 0, 0, 32'h200, 4'h8, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 2'b00, 0, 32'h203, 32'h0, 0, 1, 32'h80FF0000, 0, 0, 32'h200, 4'h8, 32'h0, 32'h00000080));
    vecs.push_back(mk(1, 2'b01, 0, 32'h302, 32'h0000ABCD, 3, 0, 32'h0, 0, 0, 32'h300, 4'hC, 32'hABCDABCD, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h102, 32'h0, 1, 0, 32'h80011234, 0, 0, 32'h100, 4'hC, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(0, 2'b01, 0, 32'h100, 32'h0, 0, 2, 32'h8001F234, 0, 0, 32'h100, 4'h3, 32'h0, 32'h0000F234));
    vecs.push_back(mk(0, 2'b00, 0, 32'h001, 32'h0, 0, 0, 32'h0000A500, 0, 0, 32'h000, 4'h2, 32'h0, 32'h000000A5));
    vecs.push_back(mk(0, 2'b10, 0, 32'h40C, 32'h0, 0, 0, 32'hCAFEF00D, 1, 0, 32'h40C, 4'hF, 32'h0, 32'h0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h401, 32'h0, 0, 0, 32'h11223344, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 1, 32'h500, 32'h0, 0, 0, 32'h55667788, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h203, 32'h0, 0, 0, 32'h7FFF0000, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h401, 32'h0, 0, 0, 32'h11223344, 0, 0, 32'h400, 4'hF, 32'h0, 32'h11223344));
    vecs.push_back(mk(0, 2'b11, 1, 32'h500, 32'h0, 0, 0, 32'h55667788, 0, 0, 32'h500, 4'hF, 32'h0, 32'h55667788));
    vecs.push_back(mk(0, 2'b01, 1, 32'h203, 32'h0, 0, 0, 32'h7FFF0000, 0, 0, 32'h200, 4'hC, 32'h0, 32'h00007FFF));
`endif
    vecs.push_back(mk(1, 2'b00, 0, 32'h002, 32'h123456AB, 0, 0, 32'hFFFFFFFF, 0, 0, 32'h000, 4'h4, 32'hABABABAB, 32'h0));

    rst = 1'b1; lsu_req_i = 0; lsu_we_i = 0; lsu_type_i = 0; lsu_sign_ext_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0; core_ready_i = 0; resp_valid_i = 0;
    resp_rdata_i = 0; resp_err_i = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort an access with reset while waiting for the response.
    vr = mk(0, 2'b10, 0, 32'h600, 32'h0, 0, 0, 32'h0, 0, 0, 32'h600, 4'hF, 32'h0, 32'h0);
    drive_req(vr);
    push_model(vr, 1'b0);
    @(posedge clk); #1;
    core_ready_i = 1'b1;
    @(posedge clk); #1;
    core_ready_i = 1'b0;
    lsu_req_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp_stall", {31'd0, lsu_stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_valid_i = 1'b1; resp_rdata_i = 32'hFFFFFFFF; resp_err_i = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk); #1;
    resp_valid_i = 1'b0; resp_err_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
      chk("abort_idle_stall", {31'd0, lsu_stall_o}, 32'd0);
      @(posedge clk); #1;
    end

    run_vec(vecs[0]);

    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("cq_drained", 32'(cq.size()), 32'd0);
    chk("mis_drained", 32'(mis_pending), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
